// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port arbiter/sequencer in front of a single-port DataMemory
//   clk, resetN (async, active-low)
//   port N (0 = MEM stage, 1 = debug/DMA): reqN, weN, widthN, extN, addrN, wdataN in;
//     ackN (one-cycle pulse), errN (misaligned, valid with ack), rdataN (held until next ack) out
//   memory side: memWriteEnable, memWidthCtrl, memExtendCtrl, memAddress, memWriteData out;
//     memReadData in (combinational)
`ifndef memWidth4
`define memWidth4 2'b10
`endif
`ifndef memWidth2
`define memWidth2 2'b01
`endif
`ifndef memWidth1
`define memWidth1 2'b00
`endif
module dm_port_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  width0,
  input  logic [1:0]  width1,
  input  logic        ext0,
  input  logic        ext1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        memWriteEnable,
  output logic [1:0]  memWidthCtrl,
  output logic        memExtendCtrl,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, stateNext;
  logic anyReq, grant1, selWe, selExt, selMis;
  logic [1:0] selWidth;
  logic [31:0] selAddr, selWdata;
  logic winner, lastWinner, misaligned, isLoad;
  logic [CW-1:0] starveCnt;
  // port 1 wins only when it requests and either port 0 is idle or the tie-break favours it
  always_comb begin
    anyReq = req0 | req1;
    grant1 = req1 & (~req0 | (FIXED_PRIORITY ? (starveCnt == LIMIT) : ~lastWinner));
    selWe = grant1 ? we1 : we0;
    selWidth = grant1 ? width1 : width0;
    selExt = grant1 ? ext1 : ext0;
    selAddr = grant1 ? addr1 : addr0;
    selWdata = grant1 ? wdata1 : wdata0;
    selMis = (selWidth == `memWidth4 && selAddr[1:0] != 2'b00) || (selWidth == `memWidth2 && selAddr[0]);
    stateNext = state == IDLE ? (anyReq ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      memWriteEnable <= 1'b0;
      memWidthCtrl <= '0;
      memExtendCtrl <= 1'b0;
      memAddress <= '0;
      memWriteData <= '0;
      winner <= 1'b0;
      lastWinner <= 1'b1;
      misaligned <= 1'b0;
      isLoad <= 1'b0;
      starveCnt <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (state == IDLE) begin
        // counts consecutive losses of a waiting port 1; any idle cycle of req1 forgives them
        starveCnt <= (~req1 | grant1) ? '0 : (starveCnt == LIMIT ? starveCnt : starveCnt + 1'b1);
        if (anyReq) begin
          winner <= grant1;
          lastWinner <= grant1;
          misaligned <= selMis;
          isLoad <= ~selWe;
          memWriteEnable <= selWe & ~selMis;
          memWidthCtrl <= selWidth;
          memExtendCtrl <= selExt;
          memAddress <= selAddr;
          memWriteData <= selWdata;
        end
      end
      if (state == ACCESS) begin
        memWriteEnable <= 1'b0;
        ack0 <= ~winner;
        ack1 <= winner;
        err0 <= ~winner & misaligned;
        err1 <= winner & misaligned;
        if (isLoad & ~misaligned & ~winner) rdata0 <= memReadData;
        if (isLoad & ~misaligned & winner) rdata1 <= memReadData;
      end
    end
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed and randomized checks of dm_port_arbiter against a transaction-level model
module tb_dm_port_arbiter;
  localparam logic [1:0] W4 = 2'b10, W2 = 2'b01, W1 = 2'b00;
  localparam int LIM = 8;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  logic rq[2], rqB[2], cWe[2], cE[2];
  logic [1:0] cW[2];
  logic [31:0] cA[2], cD[2];
  logic ack0, ack1, err0, err1, mwe, mext;
  logic [31:0] rdata0, rdata1, maddr, mwd, mrd;
  logic [1:0] mw;
  logic ackB0, ackB1, errB0, errB1, mweB, mextB;
  logic [31:0] rdB0, rdB1, maddrB, mwdB;
  logic [1:0] mwB;
  logic [31:0] mrdB = 32'h0;
  logic [7:0] memA [1024];
  logic [7:0] refMem [1024];
  logic [9:0] ma0, ma1, ma2, ma3;
  logic [31:0] expR[2];
  int checks = 0, failures = 0;
  int cd, ackIn, loss, n, lastAck;
  logic win, ackP, tWe, tMis, expP;
  logic [31:0] tAddr, tExp;

  function automatic logic [31:0] fmt(input logic [7:0] b0, b1, b2, b3, input logic [1:0] w, input logic e);
    if (w == W4) return {b3, b2, b1, b0};
    if (w == W2) return {{16{e & b1[7]}}, b1, b0};
    return {{24{e & b0[7]}}, b0};
  endfunction

  function automatic logic misF(input logic [1:0] w, input logic [1:0] a);
    return (w == W4 && a != 2'b00) || (w == W2 && a[0]);
  endfunction

  function automatic logic [31:0] refRead(input logic [1:0] w, input logic e, input logic [9:0] i);
    return fmt(refMem[i], refMem[i + 10'd1], refMem[i + 10'd2], refMem[i + 10'd3], w, e);
  endfunction

  assign ma0 = maddr[9:0];
  assign ma1 = ma0 + 10'd1;
  assign ma2 = ma0 + 10'd2;
  assign ma3 = ma0 + 10'd3;
  assign mrd = fmt(memA[ma0], memA[ma1], memA[ma2], memA[ma3], mw, mext);
  always @(posedge clk)
    if (mwe) begin
      memA[ma0] <= mwd[7:0];
      if (mw != W1) memA[ma1] <= mwd[15:8];
      if (mw == W4) begin
        memA[ma2] <= mwd[23:16];
        memA[ma3] <= mwd[31:24];
      end
    end

  dm_port_arbiter dut (
    .clk(clk), .resetN(resetN),
    .req0(rq[0]), .req1(rq[1]), .we0(cWe[0]), .we1(cWe[1]),
    .width0(cW[0]), .width1(cW[1]), .ext0(cE[0]), .ext1(cE[1]),
    .addr0(cA[0]), .addr1(cA[1]), .wdata0(cD[0]), .wdata1(cD[1]),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .memWriteEnable(mwe), .memWidthCtrl(mw), .memExtendCtrl(mext),
    .memAddress(maddr), .memWriteData(mwd), .memReadData(mrd)
  );

  dm_port_arbiter #(.FIXED_PRIORITY(1'b0)) dutRr (
    .clk(clk), .resetN(resetN),
    .req0(rqB[0]), .req1(rqB[1]), .we0(cWe[0]), .we1(cWe[1]),
    .width0(cW[0]), .width1(cW[1]), .ext0(cE[0]), .ext1(cE[1]),
    .addr0(cA[0]), .addr1(cA[1]), .wdata0(cD[0]), .wdata1(cD[1]),
    .ack0(ackB0), .ack1(ackB1), .err0(errB0), .err1(errB1), .rdata0(rdB0), .rdata1(rdB1),
    .memWriteEnable(mweB), .memWidthCtrl(mwB), .memExtendCtrl(mextB),
    .memAddress(maddrB), .memWriteData(mwdB), .memReadData(mrdB)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic refWrite(input logic [1:0] w, input logic [9:0] i, input logic [31:0] d);
    refMem[i] = d[7:0];
    if (w != W1) refMem[i + 10'd1] = d[15:8];
    if (w == W4) begin
      refMem[i + 10'd2] = d[23:16];
      refMem[i + 10'd3] = d[31:24];
    end
  endtask

  task automatic setCmd(input int p, input logic we, input logic [1:0] w, input logic e, input logic [31:0] a, input logic [31:0] d);
    cWe[p] = we;
    cW[p] = w;
    cE[p] = e;
    cA[p] = a;
    cD[p] = d;
  endtask

  task automatic newRand(input int p);
    int k;
    logic [1:0] w;
    logic [31:0] a;
    k = int'($urandom % 3);
    w = k == 0 ? W1 : k == 1 ? W2 : W4;
    a = 32'h100 + ($urandom % 64);
    if ($urandom % 4 != 0) a = w == W4 ? {a[31:2], 2'b00} : w == W2 ? {a[31:1], 1'b0} : a;
    setCmd(p, 1'($urandom % 2), w, 1'($urandom % 2), a, $urandom);
  endtask

  // single request from an idle arbiter: ACCESS after one edge, ack after two, idle after three
  task automatic txn(input int p, input logic we, input logic [1:0] w, input logic e, input logic [31:0] a, input logic [31:0] d);
    logic m;
    logic [31:0] ex;
    m = misF(w, a[1:0]);
    ex = (!we && !m) ? refRead(w, e, a[9:0]) : expR[p];
    setCmd(p, we, w, e, a, d);
    rq[p] = 1'b1;
    step;
    chk1("txn_mwe", mwe, we & ~m);
    chk("txn_addr", maddr, a);
    chk("txn_wdata", mwd, d);
    chk("txn_width", 32'(mw), 32'(w));
    chk1("txn_ack_early", p != 0 ? ack1 : ack0, 1'b0);
    if (we && !m) refWrite(w, a[9:0], d);
    step;
    chk1("txn_ack", p != 0 ? ack1 : ack0, 1'b1);
    chk1("txn_ack_other", p != 0 ? ack0 : ack1, 1'b0);
    chk1("txn_err", p != 0 ? err1 : err0, m);
    expR[p] = ex;
    chk("txn_rdata0", rdata0, expR[0]);
    chk("txn_rdata1", rdata1, expR[1]);
    chk1("txn_mwe_done", mwe, 1'b0);
    rq[p] = 1'b0;
    step;
    chk1("txn_ack_low", p != 0 ? ack1 : ack0, 1'b0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0;
      rqB[p] = 1'b0;
      expR[p] = '0;
    end
    setCmd(1, 1'b0, W4, 1'b0, 32'h0, 32'h0);
    setCmd(0, 1'b1, W4, 1'b0, 32'h100, 32'hA5A50001);
    rq[0] = 1'b1;
    repeat (3) step;
    chk("rst_flags", 32'({ack0, ack1, err0, err1, mwe, mext, mw}), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_addr", maddr, 32'h0);
    chk("rst_wdata", mwd, 32'h0);
    resetN = 1'b1;
    txn(0, 1'b1, W4, 1'b0, 32'h100, 32'hA5A50001);
    for (int i = 0; i < 16; i++) txn(0, 1'b1, W4, 1'b0, 32'h100 + 32'(i * 4), $urandom);
    txn(0, 1'b1, W4, 1'b0, 32'h100, 32'h12345678);
    txn(0, 1'b0, W4, 1'b0, 32'h100, 32'h0);
    chk("t2_lw", rdata0, 32'h12345678);
    txn(1, 1'b1, W1, 1'b0, 32'h103, 32'h555555AB);
    txn(1, 1'b0, W1, 1'b1, 32'h103, 32'h0);
    chk("t3_lb", rdata1, 32'hFFFFFFAB);
    txn(1, 1'b0, W1, 1'b0, 32'h103, 32'h0);
    chk("t3_lbu", rdata1, 32'h000000AB);
    txn(0, 1'b0, W2, 1'b1, 32'h101, 32'h0);
    chk("t6_lh_rdata", rdata0, 32'h12345678);
    txn(0, 1'b1, W4, 1'b0, 32'h102, 32'hDEADBEEF);
    txn(0, 1'b0, W4, 1'b0, 32'h100, 32'h0);
    chk("t6_mem_kept", rdata0, 32'hAB345678);
    setCmd(0, 1'b0, W4, 1'b0, 32'h100, 32'h0);
    setCmd(1, 1'b0, W4, 1'b0, 32'h104, 32'h0);
    rq[0] = 1'b1;
    rq[1] = 1'b1;
    loss = 0;
    n = 0;
    lastAck = 0;
    for (int c = 1; c <= 54; c++) begin
      step;
      if (ack0 | ack1) begin
        expP = loss == LIM;
        loss = expP ? 0 : loss + 1;
        chk1("t4_grant", ack1, expP);
        chk1("t4_onehot", ack0 & ack1, 1'b0);
        chk("t4_rdata", expP ? rdata1 : rdata0, refRead(W4, 1'b0, expP ? 10'h104 : 10'h100));
        if (n > 0) chk("t4_spacing", c - lastAck, 3);
        lastAck = c;
        n++;
      end
    end
    chk("t4_count", n, 18);
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    expR[0] = refRead(W4, 1'b0, 10'h100);
    expR[1] = refRead(W4, 1'b0, 10'h104);
    step;
    rqB[0] = 1'b1;
    rqB[1] = 1'b1;
    n = 0;
    lastAck = 0;
    for (int c = 1; c <= 24; c++) begin
      step;
      if (ackB0 | ackB1) begin
        chk1("t5_grant", ackB1, 1'(n % 2));
        chk1("t5_onehot", ackB0 & ackB1, 1'b0);
        if (n > 0) chk("t5_spacing", c - lastAck, 3);
        lastAck = c;
        n++;
      end
    end
    chk("t5_count", n, 8);
    rqB[0] = 1'b0;
    rqB[1] = 1'b0;
    chk("t5_flags", 32'({errB0, errB1, mweB, mextB, mwB}), 32'({4'b0000, W4}));
    chk("t5_addr", maddrB, 32'h104);
    chk("t5_rdata", rdB0 | rdB1 | mwdB, 32'h0);
    cd = 0;
    ackIn = -1;
    loss = 0;
    tWe = 1'b0;
    tMis = 1'b0;
    tAddr = '0;
    tExp = '0;
    ackP = 1'b0;
    for (int c = 0; c < 640; c++) begin
      if (cd == 0) begin
        if (rq[0] | rq[1]) begin
          win = rq[1] & (~rq[0] | (loss == LIM));
          loss = (rq[1] & ~win) ? (loss < LIM ? loss + 1 : LIM) : 0;
          tWe = cWe[win];
          tAddr = cA[win];
          tMis = misF(cW[win], cA[win][1:0]);
          tExp = (!tWe && !tMis) ? refRead(cW[win], cE[win], cA[win][9:0]) : expR[win];
          if (tWe && !tMis) refWrite(cW[win], cA[win][9:0], cD[win]);
          ackP = win;
          ackIn = 2;
          cd = 3;
        end else loss = 0;
      end
      step;
      if (cd > 0) cd--;
      if (ackIn >= 0) ackIn--;
      chk1("rand_mwe", mwe, cd == 2 && tWe && !tMis);
      if (cd == 2) chk("rand_addr", maddr, tAddr);
      chk1("rand_ack0", ack0, ackIn == 0 && !ackP);
      chk1("rand_ack1", ack1, ackIn == 0 && ackP);
      if (ackIn == 0) begin
        chk1("rand_err", ackP ? err1 : err0, tMis);
        expR[ackP] = tExp;
        rq[ackP] = 1'b0;
      end
      chk("rand_rdata0", rdata0, expR[0]);
      chk("rand_rdata1", rdata1, expR[1]);
      if (c < 600)
        for (int p = 0; p < 2; p++)
          if (!rq[p] && ($urandom % 4) < (p != 0 ? 2 : 3)) begin
            newRand(p);
            rq[p] = 1'b1;
          end
    end
    chk1("rand_drained", rq[0] | rq[1], 1'b0);
    setCmd(0, 1'b1, W4, 1'b0, 32'h108, 32'h0BADF00D);
    rq[0] = 1'b1;
    step;
    chk1("arst_mwe_before", mwe, 1'b1);
    #2 resetN = 1'b0;
    #1;
    chk1("arst_mwe_async", mwe, 1'b0);
    rq[0] = 1'b0;
    step;
    chk1("arst_no_ack", ack0, 1'b0);
    chk("arst_addr", maddr, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
